// File: rtl/rtm_rd_ctrl_if.sv
// Command, bank-read and output-stream signals of the RTM read controller.
// "master" is the controller side; "slave" is the command source, banks and downstream.
interface rtm_rd_ctrl_if #(
  parameter int S  = 16,
  parameter int R  = 16,
  parameter int AW = 12
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [AW-1:0]      cmd_addr;
  logic [AW:0]        cmd_len;
  logic [S-1:0]       rd_en;
  logic [S*AW-1:0]    rd_addr;
  logic [S*R*8-1:0]   dout;
  logic               m_valid;
  logic               m_ready;
  logic [S*R*8-1:0]   m_data;
  logic               m_last;
  logic               busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, dout, m_ready,
    output cmd_ready, rd_en, rd_addr, m_valid, m_data, m_last, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, dout, m_ready,
    input  cmd_ready, rd_en, rd_addr, m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/rtm_rd_ctrl.sv
// RTM read controller: issues row reads to all banks, tags the fixed bank latency
// and buffers returned rows in a credit-protected FIFO feeding a valid/ready stream.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   ISSUE | issuing reads while credits allow
//   DRAIN | all reads issued, waiting for the last beat handshake
module rtm_rd_ctrl #(
  parameter int S          = 16,
  parameter int R          = 16,
  parameter int DEPTH      = 4096,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input logic           clk,
  input logic           rstn,
  rtm_rd_ctrl_if.master bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int DW  = S * R * 8;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = FAW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic              init_done;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       remain;
  logic              rd_en_q;
  logic              rd_last_q;
  logic [AW-1:0]     rd_addr_q;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_last;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [FAW-1:0]    wr_idx;
  logic [FAW-1:0]    rd_idx;
  logic [DW-1:0]     fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];

  logic accept;
  logic issue;
  logic last_issue;
  logic fifo_wr;
  logic fifo_pop;
  logic fifo_empty;

  assign accept     = bus.cmd_valid & bus.cmd_ready;
  // A read only goes out if a FIFO slot is guaranteed for its data.
  assign issue      = (state == ISSUE) &&
                      (((CW+1)'(inflight) + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH));
  assign last_issue = issue && (remain == (AW+1)'(1));
  assign fifo_wr    = tag_v[RD_LAT-1];
  assign fifo_empty = (fifo_count == '0);
  assign fifo_pop   = bus.m_valid & bus.m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      init_done <= 1'b0;
      rd_ptr    <= '0;
      remain    <= '0;
      rd_en_q   <= 1'b0;
      rd_last_q <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      init_done <= 1'b1;
      rd_en_q   <= issue;
      rd_last_q <= last_issue;
      if (issue) begin
        rd_addr_q <= rd_ptr;
        rd_ptr    <= rd_ptr + AW'(1);
        remain    <= remain - (AW+1)'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            rd_ptr <= bus.cmd_addr;
            remain <= bus.cmd_len;
            if (bus.cmd_len != '0) state <= ISSUE;
          end
        end
        ISSUE:   if (last_issue) state <= DRAIN;
        DRAIN:   if (fifo_pop && bus.m_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_v    <= '0;
      tag_last <= '0;
      inflight <= '0;
    end else begin
      tag_v[0]    <= rd_en_q;
      tag_last[0] <= rd_last_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_last[i] <= tag_last[i-1];
      end
      case ({issue, fifo_wr})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr)  wr_idx <= wr_idx + FAW'(1);
      if (fifo_pop) rd_idx <= rd_idx + FAW'(1);
      case ({fifo_wr, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_data[wr_idx] <= bus.dout;
      fifo_last[wr_idx] <= tag_last[RD_LAT-1];
    end
  end

  assign bus.cmd_ready = init_done && (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rd_en     = {S{rd_en_q}};
  assign bus.rd_addr   = {S{rd_addr_q}};
  assign bus.m_valid   = !fifo_empty;
  // Storage is not reset, so the head is masked to zero while nothing is buffered.
  assign bus.m_data    = fifo_empty ? '0 : fifo_data[rd_idx];
  assign bus.m_last    = !fifo_empty && fifo_last[rd_idx];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
                                  !(fifo_wr && (fifo_count == CW'(FIFO_DEPTH))))
    else $error("rtm_rd_ctrl: FIFO write while full");
endmodule

// File: tb/tb_rtm_rd_ctrl.sv
// Scoreboard bench for rtm_rd_ctrl: bank model, queued expectations, decoupled monitor.
module tb_rtm_rd_ctrl;
  localparam int S          = 16;
  localparam int R          = 16;
  localparam int DEPTH      = 4096;
  localparam int RD_LAT     = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int AW         = $clog2(DEPTH);
  localparam int DW         = S * R * 8;

  typedef struct {
    int addr;
    bit last;
  } beat_t;

  logic clk;
  logic rstn;

  rtm_rd_ctrl_if #(.S(S), .R(R), .AW(AW)) bus ();

  rtm_rd_ctrl #(.S(S), .R(R), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    rdy_mode = 1;
  beat_t exp_beats[$];
  int    exp_addrs[$];
  bit    exp_busy = 0;
  int    acc_cyc = 0;
  int    first_rd_cyc = -1;
  int    first_valid_cyc = -1;
  int    last_beat_cyc = -1;
  int    issue_cnt = 0;
  int    seen_rd = 0;
  int    seen_valid = 0;
  int    seen_busy = 0;
  int    seen_notready = 0;
  int    beats = 0;

  // Row k of bank i holds {i,k} in its low 32 bits and the inverse in the next 32.
  function automatic logic [DW-1:0] row_data(input int k);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < S; i++) begin
      d[i*R*8 +: 32]      = {16'(i), 16'(k)};
      d[i*R*8 + 32 +: 32] = ~{16'(i), 16'(k)};
    end
    return d;
  endfunction

  function automatic logic [DW-1:0] garbage();
    logic [DW-1:0] g;
    for (int i = 0; i < DW / 32; i++) g[i*32 +: 32] = $urandom;
    return g;
  endfunction

  task automatic chk(input string nm, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    chk({tag, "_rd_en"},     bus.rd_en == '0, 1);
    chk({tag, "_rd_addr"},   bus.rd_addr == '0, 1);
    chk({tag, "_m_valid"},   bus.m_valid, 0);
    chk({tag, "_m_last"},    bus.m_last, 0);
    chk({tag, "_m_data"},    bus.m_data == '0, 1);
    chk({tag, "_busy"},      bus.busy, 0);
  endtask

  task automatic send_cmd(input int a, input int l);
    bit got;
    got = 0;
    @(posedge clk);
    #1;
    bus.cmd_addr  = AW'(a);
    bus.cmd_len   = (AW+1)'(l);
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      got = bus.cmd_ready;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL cmd_accept: cmd_ready stayed 0, expected 1");
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid   = 1'b0;
    acc_cyc         = cyc;
    first_rd_cyc    = -1;
    first_valid_cyc = -1;
    issue_cnt       = 0;
    for (int j = 0; j < l; j++) begin
      exp_addrs.push_back((a + j) % DEPTH);
      exp_beats.push_back('{(a + j) % DEPTH, j == l - 1});
    end
    if (l > 0) exp_busy = 1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(exp_beats.size() == 0 && !bus.m_valid && !bus.busy) && t < 3000);
    chk("drain_within_budget", t < 3000, 1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Bank model: a sampled read appears on dout RD_LAT cycles after rd_en is presented.
  initial begin
    bit pv[RD_LAT];
    int pa[RD_LAT];
    bit s_en;
    int s_addr;
    for (int i = 0; i < RD_LAT; i++) begin
      pv[i] = 0;
      pa[i] = 0;
    end
    bus.dout = garbage();
    forever begin
      @(negedge clk);
      s_en   = bus.rd_en[0];
      s_addr = int'(bus.rd_addr[AW-1:0]);
      @(posedge clk);
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = s_en;
      pa[0] = s_addr;
      #1;
      bus.dout = pv[RD_LAT-1] ? row_data(pa[RD_LAT-1]) : garbage();
    end
  end

  initial begin
    logic [DW-1:0] pdata;
    logic [DW-1:0] want;
    bit            plast;
    bit            pstall;
    beat_t         e;
    int            a;
    pstall = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pstall = 0;
      end else begin
        chk("ready_busy_exclusive", bus.busy & bus.cmd_ready, 0);
        chk("busy", bus.busy, exp_busy);
        if (pstall)
          chk("hold_while_stalled", bus.m_valid && (bus.m_data == pdata) && (bus.m_last == plast), 1);
        if (bus.rd_en != '0) begin
          chk("rd_uniform", (bus.rd_en == {S{1'b1}}) && (bus.rd_addr == {S{bus.rd_addr[AW-1:0]}}), 1);
          seen_rd++;
          issue_cnt++;
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          if (exp_addrs.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got read of row %0d, expected none", bus.rd_addr[AW-1:0]);
          end else begin
            a = exp_addrs.pop_front();
            chk("rd_addr", bus.rd_addr[AW-1:0], a);
          end
        end
        if (bus.m_valid) begin
          seen_valid++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (bus.m_valid && bus.m_ready) begin
          beats++;
          if (exp_beats.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: got beat low64 %h, expected none", bus.m_data[63:0]);
          end else begin
            e    = exp_beats.pop_front();
            want = row_data(e.addr);
            total++;
            if (bus.m_data !== want) begin
              bad++;
              $display("FAIL m_data row %0d: got low64 %h, expected low64 %h", e.addr, bus.m_data[63:0], want[63:0]);
            end
            chk("m_last", bus.m_last, e.last);
            if (e.last) begin
              last_beat_cyc = cyc;
              exp_busy      = 0;
            end
          end
        end
        pstall = bus.m_valid && !bus.m_ready;
        pdata  = bus.m_data;
        plast  = bus.m_last;
        if (bus.busy) seen_busy++;
        if (!bus.cmd_ready) seen_notready++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    int s_rd;
    int s_valid;
    int s_busy;
    int s_nr;
    int s_beats;
    int a;
    int l;
    rstn          = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rstn = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", bus.cmd_ready, 1);

    rdy_mode = 1;
    send_cmd(10, 4);
    wait_drain();
    chk("first_rd_latency", first_rd_cyc - acc_cyc, 1);
    chk("first_valid_latency", first_valid_cyc - acc_cyc, RD_LAT + 2);
    chk("last_beat_latency", last_beat_cyc - acc_cyc, 4 + RD_LAT + 1);

    send_cmd(DEPTH - 2, 4);
    wait_drain();
    chk("wrap_last_beat_latency", last_beat_cyc - acc_cyc, 4 + RD_LAT + 1);

    rdy_mode = 0;
    s_beats  = beats;
    send_cmd(0, 32);
    repeat (20) @(negedge clk);
    chk("issued_before_first_pop", issue_cnt, FIFO_DEPTH);
    chk("no_beat_while_stalled", beats - s_beats, 0);
    chk("valid_while_stalled", bus.m_valid, 1);
    rdy_mode = 2;
    wait_drain();
    chk("backpressure_beat_count", beats - s_beats, 32);

    rdy_mode = 1;
    s_rd = seen_rd; s_valid = seen_valid; s_busy = seen_busy; s_nr = seen_notready;
    send_cmd(5, 0);
    repeat (10) @(negedge clk);
    chk("zero_len_rd_en", seen_rd - s_rd, 0);
    chk("zero_len_m_valid", seen_valid - s_valid, 0);
    chk("zero_len_busy", seen_busy - s_busy, 0);
    chk("zero_len_cmd_ready_low", seen_notready - s_nr, 0);

    send_cmd(100, 16);
    n = 0;
    t = 0;
    while (n < 5 && t < 100) begin
      @(negedge clk);
      t++;
      if (bus.rd_en[0]) n++;
    end
    chk("reset_trigger_issue_count", n, 5);
    rstn = 1'b0;
    exp_beats.delete();
    exp_addrs.delete();
    exp_busy = 0;
    @(negedge clk);
    check_reset("midop");
    @(negedge clk);
    rstn    = 1'b1;
    s_valid = seen_valid;
    s_rd    = seen_rd;
    repeat (12) @(negedge clk);
    chk("no_valid_after_reset", seen_valid - s_valid, 0);
    chk("no_rd_after_reset", seen_rd - s_rd, 0);
    s_beats = beats;
    send_cmd(0, 2);
    wait_drain();
    chk("beats_after_reset", beats - s_beats, 2);

    send_cmd(0, 3);
    send_cmd(20, 1);
    chk("b2b_accept_after_last", acc_cyc - last_beat_cyc, 2);
    wait_drain();

    rdy_mode = 2;
    for (int k = 0; k < 10; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 24);
      send_cmd(a, l);
    end
    wait_drain();
    chk("addr_queue_empty", exp_addrs.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rtm_rd_ctrl.md
# rtm_rd_ctrl

- Read controller placed directly upstream of the RTM memory array.
- Accepts one command per transfer: a start row address and a row count.
- Drives identical row addresses to all S URAM banks, tracks the fixed read latency of the banks, and buffers the returned rows.
- Emits the rows as a valid/ready stream of S*R*8-bit beats to the next compute stage, using credit-based flow control so that no returned row is ever dropped.

## Interface
Parameters:
- S, 16, number of RTM banks.
- R, 16, bytes per bank row.
- DEPTH, 4096, rows per bank; power of two. AW = $clog2(DEPTH).
- RD_LAT, 3, cycles from rd_en sample to dout valid. Equals bank pipeline depth + 1.
- FIFO_DEPTH, 8, output buffer entries; power of two, must be ≥ RD_LAT+2.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller idle; command accepted on cmd_valid&cmd_ready.
- cmd_addr  in  AW  first row address.
- cmd_len  in  AW+1  row count, 0..DEPTH.
- rd_en  out  S  per-bank read enable; all bits always equal.
- rd_addr  out  S*AW  per-bank address; all S fields always equal.
- dout  in  S*R*8  bank read data; bank i occupies bits [i*R*8 +: R*8].
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  S*R*8  output beat, same bank ordering as dout.
- m_last  out  1  marks the final beat of a command.
- busy  out  1  high from command accept until the last beat is accepted.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr into rd_ptr and len into remain.
  - len=0 → stay IDLE. No reads, no beats, busy never rises.
  - len>0 → ISSUE.
- ISSUE: a read is issued in a cycle iff (inflight + fifo_count) < FIFO_DEPTH.
  - inflight = number of reads issued whose data has not yet returned.
  - On issue: rd_en=all ones, rd_addr=rd_ptr, rd_ptr+1, remain-1.
  - The issue with remain=1 → DRAIN.
- rd_ptr wraps modulo DEPTH: address DEPTH-1 is followed by 0. No error is raised.
- Return path:
  - A valid shift register of length RD_LAT tags each issued read.
  - When its tap fires, dout is written into the FIFO.
  - The tag for the final read also carries a last flag, stored alongside the data.
- Credit accounting guarantees the FIFO never overflows. An FIFO write that finds the FIFO full is a design error; guard it with an assertion.
- Output: FIFO head is presented on m_data/m_last with m_valid=!empty; it pops on m_valid&m_ready.
- DRAIN: wait for the beat with m_last to be accepted → IDLE.
- Simultaneous FIFO write and pop in one cycle are both honoured; fifo_count is unchanged.
- m_data/m_last hold stable while m_valid=1 and m_ready=0.

## Timing
- Reset values (asynchronous on rstn low): cmd_ready=0, rd_en=0, rd_addr=0, m_valid=0, m_last=0, m_data=0, busy=0.
- State resets to IDLE. Tag pipeline, FIFO pointers, counters and remain all clear.
- cmd_ready rises in the first clock after rstn deasserts.
- Reset mid-transfer: all in-flight tags and buffered beats are discarded. Returning dout after reset is ignored.
- Cycle latency, with a command accepted at edge 0:
  - First rd_en at cycle 1.
  - Data written into the FIFO at cycle 1+RD_LAT.
  - First m_valid at cycle 2+RD_LAT.
- With m_ready held high and FIFO_DEPTH ≥ RD_LAT+2, one read is issued and one beat is emitted per cycle.
- Total command latency is len+RD_LAT+1 cycles from accept to the last beat.
- busy and cmd_ready are mutually exclusive after reset release.
- The next command is accepted at the earliest in the cycle after the last beat handshake.

## Test plan
- Basic read: preload row k of bank i with {i,k}; cmd addr=10, len=4, m_ready=1.
  - Expect beats for rows 10..13, m_last on the 4th beat only.
  - First m_valid exactly RD_LAT+2 cycles after accept.
- Wrap: cmd addr=DEPTH-2, len=4.
  - Expect rd_addr sequence DEPTH-2, DEPTH-1, 0, 1, with data in the same order.
- Backpressure: len=32, m_ready=0 for 20 cycles, then random.
  - At most FIFO_DEPTH reads are issued before the first pop.
  - No beat lost or duplicated; rows arrive in order 0..31.
- Zero length: cmd len=0.
  - Expect no rd_en, no m_valid, busy stays 0, cmd_ready stays 1.
- Reset mid-op: len=16, assert rstn low at the 5th issue for 2 cycles, release.
  - All outputs at their reset values during reset; no m_valid afterwards.
  - A new cmd addr=0, len=2 then returns exactly 2 correct beats.
- Back-to-back commands: len=3, then len=1.
  - Second accept occurs on the cycle after the first m_last handshake.
  - Beat stream shows m_last on beats 3 and 4.
